// File: rtl/branch_cache_update_ctrl.sv
// branch_cache_update_ctrl: two-port round-robin update queue that drains {pc,target} writes into the branch cache.
// Define BCU_COALESCE_EN to merge a request into a queued entry with the same pc instead of allocating a new one.
module branch_cache_update_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       a_valid_i,
    input  logic [9:0]                 a_pc_i,
    input  logic [9:0]                 a_target_i,
    output logic                       a_ready_o,
    input  logic                       b_valid_i,
    input  logic [9:0]                 b_pc_i,
    input  logic [9:0]                 b_target_i,
    output logic                       b_ready_o,
    input  logic                       flush_i,
    input  logic                       cache_busy_i,
    output logic                       bc_we_o,
    output logic [9:0]                 bc_update_pc_o,
    output logic [9:0]                 bc_store_pc_o,
    output logic [$clog2(DEPTH):0]     pending_o,
    output logic                       idle_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_e;

    state_e          state_q, state_d;
    logic [9:0]      pc_mem [DEPTH];
    logic [9:0]      tg_mem [DEPTH];
    logic [AW-1:0]   wr_q, rd_q, hit_idx;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic            rr_q, bc_we_q;
    logic [9:0]      bc_update_pc_q, bc_store_pc_q, req_pc, req_tg;
    logic            grant_a, grant_b, full, pop, acc, push, hit;

    // rr_q set means port A won last, so port B is preferred on contention
    assign grant_a = a_valid_i && (!b_valid_i || !rr_q);
    assign grant_b = b_valid_i && !grant_a;
    assign req_pc  = grant_a ? a_pc_i : b_pc_i;
    assign req_tg  = grant_a ? a_target_i : b_target_i;
    assign full    = state_q == FULL;
    assign pop     = state_q != EMPTY && !cache_busy_i && !flush_i;

`ifdef BCU_COALESCE_EN
    // the head leaving this cycle cannot absorb a merge; such a request becomes a new push
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (!hit && {1'b0, AW'(AW'(i) - rd_q)} < cnt_q && !(pop && AW'(i) == rd_q) && pc_mem[i] == req_pc) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
    end
`else
    assign hit     = 1'b0;
    assign hit_idx = '0;
`endif

    assign a_ready_o = grant_a && !flush_i && (!full || hit);
    assign b_ready_o = grant_b && !flush_i && (!full || hit);
    assign acc       = a_ready_o || b_ready_o;
    assign push      = acc && !hit;
    assign cnt_d     = flush_i ? '0 : cnt_q + PW'(push) - PW'(pop);
    assign state_d   = cnt_d == '0 ? EMPTY : cnt_d == PW'(DEPTH) ? FULL : ACTIVE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= EMPTY;
            cnt_q          <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            rr_q           <= 1'b0;
            bc_we_q        <= 1'b0;
            bc_update_pc_q <= '0;
            bc_store_pc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= flush_i ? '0 : wr_q + AW'(push);
            rd_q    <= flush_i ? '0 : rd_q + AW'(pop);
            bc_we_q <= pop;
            if (acc) rr_q <= grant_a;
            if (pop) begin
                bc_update_pc_q <= pc_mem[rd_q];
                bc_store_pc_q  <= tg_mem[rd_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) begin
            if (!hit) pc_mem[wr_q] <= req_pc;
            tg_mem[hit ? hit_idx : wr_q] <= req_tg;
        end
    end

    assign bc_we_o        = bc_we_q;
    assign bc_update_pc_o = bc_update_pc_q;
    assign bc_store_pc_o  = bc_store_pc_q;
    assign pending_o      = cnt_q;
    assign idle_o         = cnt_q == '0 && !bc_we_q;
endmodule

// File: doc/branch_cache_update_ctrl.md
BRANCH_CACHE_UPDATE_CTRL -- requirements
Module: branch_cache_update_ctrl

Interface
REQ-001 Parameter: DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 a_valid  in  1  execute-stage resolved-branch update request (port A).
REQ-005 a_pc, a_target  in  10 each  branch PC and taken target for port A.
REQ-006 a_ready  out  1  port A transfer accepted this cycle when a_valid && a_ready.
REQ-007 b_valid, b_pc[9:0], b_target[9:0] in, b_ready out: port B (debug/prefill), same semantics as A.
REQ-008 flush  in  1  drop all pending updates.
REQ-009 cache_busy  in  1  branch cache write slot unavailable this cycle.
REQ-010 bc_we  out  1  registered write enable to branch cache.
REQ-011 bc_update_pc, bc_store_pc  out  10 each  registered write PC and target to branch cache.
REQ-012 pending  out  clog2(DEPTH)+1  number of queued entries.
REQ-013 idle  out  1  high when pending==0 and bc_we==0.

Function
REQ-014 Requests SHALL be stored in a circular FIFO of DEPTH {pc,target} entries; read/write pointers SHALL wrap modulo DEPTH.
REQ-015 At most one push per cycle; a_ready/b_ready SHALL be combinational from valids, full, flush and the round-robin pointer, never from own ready.
REQ-016 Arbitration: single requester valid -> that requester granted; both valid -> the requester not granted on the last accepted transfer is granted; rr pointer SHALL update only on an accepted transfer.
REQ-017 Full (pending==DEPTH): both readies SHALL be 0, except REQ-024.
REQ-018 Drain: when pending>0 and cache_busy==0, head SHALL pop and bc_we, bc_update_pc, bc_store_pc SHALL present it on the next cycle for exactly one cycle; otherwise bc_we SHALL be 0 next cycle and bc_*_pc SHALL hold.
REQ-019 Latency: a request accepted at edge N into an empty queue with cache_busy low SHALL produce bc_we at cycle N+1.
REQ-020 Simultaneous push and pop SHALL be permitted when not full; pending unchanged.
REQ-021 Order: entries SHALL reach the cache in acceptance order.
REQ-022 Control FSM states: EMPTY (pending==0), ACTIVE (0<pending<DEPTH), FULL (pending==DEPTH); transitions follow pending after push/pop; FLUSH input forces EMPTY next cycle from any state.
REQ-023 flush==1: both readies 0, no pop, bc_we 0 next cycle, pointers and pending cleared next cycle; flush has priority over all other events.

Reset
REQ-024 (see Configuration) -- reserved for coalesce exception.
REQ-025 rst low SHALL immediately clear pointers, pending, rr pointer (port A preferred next), bc_we, bc_update_pc, bc_store_pc to 0; idle SHALL be 1.
REQ-026 Reset asserted mid-drain SHALL abort the write (bc_we 0 asynchronously); queued entries SHALL be lost.
REQ-027 First edge after rst deassertion SHALL behave as EMPTY.

Configuration
REQ-028 Macro BCU_COALESCE_EN defined: a granted request whose pc equals a queued entry's pc (excluding the head popping that cycle) SHALL overwrite that entry's target in place, pending unchanged, ready asserted even when full.
REQ-029 Matching the head popping that cycle SHALL be treated as a new push (subject to full).
REQ-030 Macro undefined: no compare logic; every accepted request SHALL occupy a new entry.

Verification
REQ-031 Single push: a_valid, a_pc=0x123, a_target=0x045, cache_busy=0 -> next cycle bc_we=1, bc_update_pc=0x123, bc_store_pc=0x045; then idle=1.
REQ-032 Both valid 4 cycles, cache_busy=1 -> grants A,B,A,B; pending=4; further readies 0; release busy -> 4 writes in order, one per cycle.
REQ-033 Fill to 3 entries, assert flush one cycle with a_valid -> a_ready=0, pending=0 next cycle, no bc_we.
REQ-034 With BCU_COALESCE_EN, full queue holding pc 0x010 (target 0x020), push 0x010/0x3FF -> a_ready=1, pending stays 4, drained write carries 0x3FF; without macro a_ready=0.
REQ-035 Assert rst low while bc_we=1 and pending=2 -> bc_we=0, pending=0 immediately; after release, push drains at N+1.
